// File: rtl/lcd_text_refresh_pkg.sv
// Shared LCD command constants and state encodings for the text refresh engine.
package lcd_text_refresh_pkg;

  localparam logic [7:0] LCD_FUNC_SET   = 8'h28;
  localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] LCD_DISP_CTRL  = 8'h08;
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_SET_DDRAM  = 8'h80;
  localparam logic [7:0] LCD_BLANK      = 8'h20;
  localparam logic [7:0] LCD_ROW_OFFSET = 8'h40;

  typedef enum logic [2:0] {
    INIT_FUNC,
    INIT_ENTRY,
    INIT_DISP,
    INIT_CLR,
    ROW_ADDR,
    CHAR,
    CTRL
  } lcd_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_DROP
  } hs_state_t;

  // Display-control command {RS=0, 0000_1DCB}
  function automatic logic [8:0] disp_cmd(input logic [2:0] dcb);
    return {1'b0, LCD_DISP_CTRL | {5'b0, dcb}};
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// ROWS x COLS character buffer: byte-strobed word write, word read, and a byte read for refresh.
module lcd_char_ram #(
  parameter int ROWS = 2,
  parameter int COLS = 16,
  localparam int NW = ROWS * COLS / 4,
  localparam int WW = (NW > 1) ? $clog2(NW) : 1,
  localparam int CW = $clog2(ROWS * COLS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [WW-1:0] wr_word,
  input  logic [3:0]    wr_strobe,
  input  logic [31:0]   wr_data,
  input  logic [WW-1:0] rd_word,
  output logic [31:0]   rd_data,
  input  logic [CW-1:0] char_idx,
  output logic [7:0]    char_data
);
  import lcd_text_refresh_pkg::*;

  logic [31:0] mem [NW];
  logic [31:0] char_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NW; i++) mem[WW'(i)] <= {4{LCD_BLANK}};
    end else if (wr_en) begin
      for (int unsigned k = 0; k < 4; k++)
        if (wr_strobe[k]) mem[wr_word][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  assign rd_data   = mem[rd_word];
  assign char_word = mem[WW'(char_idx >> 2)];
  // Big-endian: column offset 0 lives in byte 3
  assign char_data = char_word[{~char_idx[1:0], 3'b000} +: 8];

endmodule

// File: rtl/lcd_text_refresh.sv
// Character-LCD refresh engine: bus-mapped text buffer and control word, streamed to lcd_ctrl.
module lcd_text_refresh #(
  parameter int ROWS = 2,
  parameter int COLS = 16,
  parameter int AW   = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic [31:0]   data,
  input  logic [3:0]    writeEnable,
  input  logic          readEnable,
  output logic [31:0]   dataOut,
  output logic          ack,
  output logic [8:0]    lcd_command,
  output logic          lcd_write,
  input  logic          lcd_ack
);
  import lcd_text_refresh_pkg::*;

  localparam int NW  = ROWS * COLS / 4;
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW  = $clog2(ROWS * COLS);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = $clog2(COLS);

  logic          req, in_text, is_ctrl, ctrl_wr;
  logic [31:0]   ram_rd, rd_val;
  logic [2:0]    dcb;
  logic          ctrl_pending;

  lcd_state_t    state, state_nx;
  hs_state_t     hs, hs_nx;
  logic [RW-1:0] row, row_nx;
  logic [CLW-1:0] col, col_nx;
  logic          write_nx, latch, advance;
  logic [8:0]    cmd_sel;
  logic [7:0]    row_base, char_data;
  logic [CW-1:0] char_idx;

  assign req     = (|writeEnable) | readEnable;
  assign in_text = address < AW'(NW);
  assign is_ctrl = address == AW'(NW);
  assign ctrl_wr = is_ctrl & writeEnable[0];
  assign rd_val  = in_text ? ram_rd : (is_ctrl ? {29'b0, dcb} : '0);

  assign row_base = (row[0] ? LCD_ROW_OFFSET : 8'h00) + 8'((row >> 1) * COLS);
  assign char_idx = CW'(int'(row) * COLS + int'(col));

  lcd_char_ram #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_ram (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (in_text & (|writeEnable)),
    .wr_word  (WW'(address)),
    .wr_strobe(writeEnable),
    .wr_data  (data),
    .rd_word  (WW'(address)),
    .rd_data  (ram_rd),
    .char_idx (char_idx),
    .char_data(char_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ack          <= 1'b0;
      dataOut      <= '0;
      dcb          <= 3'b100;
      ctrl_pending <= 1'b0;
    end else begin
      ack <= req;
      if (readEnable) dataOut <= rd_val;
      if (ctrl_wr) begin
        dcb          <= data[2:0];
        ctrl_pending <= 1'b1;
      end else if (latch && state == CTRL) begin
        ctrl_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INIT_FUNC;
      hs          <= HS_IDLE;
      row         <= '0;
      col         <= '0;
      lcd_write   <= 1'b0;
      lcd_command <= '0;
    end else begin
      state     <= state_nx;
      hs        <= hs_nx;
      row       <= row_nx;
      col       <= col_nx;
      lcd_write <= write_nx;
      if (latch) lcd_command <= cmd_sel;
    end
  end

  always_comb begin
    cmd_sel = '0;
    case (state)
      INIT_FUNC:  cmd_sel = {1'b0, LCD_FUNC_SET};
      INIT_ENTRY: cmd_sel = {1'b0, LCD_ENTRY_INC};
      INIT_DISP:  cmd_sel = disp_cmd(dcb);
      INIT_CLR:   cmd_sel = {1'b0, LCD_CLEAR};
      ROW_ADDR:   cmd_sel = {1'b0, LCD_SET_DDRAM | row_base};
      CHAR:       cmd_sel = {1'b1, char_data};
      CTRL:       cmd_sel = disp_cmd(dcb);
      default:    cmd_sel = '0;
    endcase
  end

  always_comb begin
    hs_nx    = hs;
    write_nx = lcd_write;
    latch    = 1'b0;
    advance  = 1'b0;
    case (hs)
      HS_IDLE: begin
        latch    = 1'b1;
        write_nx = 1'b1;
        hs_nx    = HS_REQ;
      end
      HS_REQ: if (lcd_ack) begin
        write_nx = 1'b0;
        hs_nx    = HS_DROP;
      end
      HS_DROP: if (!lcd_ack) begin
        advance = 1'b1;
        hs_nx   = HS_IDLE;
      end
      default: hs_nx = HS_IDLE;
    endcase

    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    if (advance) begin
      case (state)
        INIT_FUNC:  state_nx = INIT_ENTRY;
        INIT_ENTRY: state_nx = INIT_DISP;
        INIT_DISP:  state_nx = INIT_CLR;
        INIT_CLR:   state_nx = ROW_ADDR;
        ROW_ADDR:   state_nx = CHAR;
        CHAR: begin
          if (col == CLW'(COLS - 1)) begin
            col_nx   = '0;
            row_nx   = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
            state_nx = ctrl_pending ? CTRL : ROW_ADDR;
          end else begin
            col_nx = col + 1'b1;
          end
        end
        CTRL:       state_nx = ROW_ADDR;
        default:    state_nx = INIT_FUNC;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Directed bench for lcd_text_refresh with a behavioural lcd_ctrl handshake model.
module tb_lcd_text_refresh;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, rst_b;
  logic [3:0]  address;
  logic [31:0] data;
  logic [3:0]  writeEnable;
  logic        readEnable;
  logic [31:0] dataOut;
  logic        ack;
  logic [8:0]  lcd_command;
  logic        lcd_write;
  logic        lcd_ack = 1'b0;

  logic [31:0] dataOut_b;
  logic        ack_b;
  logic [8:0]  cmd_b;
  logic        write_b;
  logic        lcd_ack_b = 1'b0;

  int unsigned passed = 0, total = 0;
  logic [8:0]  qa[$], qb[$];
  int unsigned cnt_a = 0, cnt_b = 0;
  logic        pw_a = 1'b0, pw_b = 1'b0;
  logic [8:0]  pc_a = '0;

  lcd_text_refresh #(.ROWS(2), .COLS(16), .AW(4)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data),
    .writeEnable(writeEnable), .readEnable(readEnable), .dataOut(dataOut), .ack(ack),
    .lcd_command(lcd_command), .lcd_write(lcd_write), .lcd_ack(lcd_ack)
  );

  lcd_text_refresh #(.ROWS(4), .COLS(20), .AW(5)) dut_b (
    .clock(clock), .reset(rst_b), .address(5'd0), .data(32'd0),
    .writeEnable(4'd0), .readEnable(1'b0), .dataOut(dataOut_b), .ack(ack_b),
    .lcd_command(cmd_b), .lcd_write(write_b), .lcd_ack(lcd_ack_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  // lcd_ctrl model: ack 3 cycles after write rises, drops 1 cycle after write falls
  always @(posedge clock) begin
    if (reset) begin
      lcd_ack <= 1'b0; cnt_a <= 0;
    end else if (lcd_write) begin
      if (cnt_a >= 2) lcd_ack <= 1'b1; else cnt_a <= cnt_a + 1;
    end else begin
      lcd_ack <= 1'b0; cnt_a <= 0;
    end
  end

  always @(posedge clock) begin
    if (rst_b) begin
      lcd_ack_b <= 1'b0; cnt_b <= 0;
    end else if (write_b) begin
      if (cnt_b >= 2) lcd_ack_b <= 1'b1; else cnt_b <= cnt_b + 1;
    end else begin
      lcd_ack_b <= 1'b0; cnt_b <= 0;
    end
  end

  always @(negedge clock) begin
    if (lcd_write && !pw_a) qa.push_back(lcd_command);
    if (lcd_write && pw_a) check("cmd_hold", {23'b0, lcd_command}, {23'b0, pc_a});
    pw_a = lcd_write;
    pc_a = lcd_command;
    if (write_b && !pw_b && cmd_b[8:7] == 2'b01) qb.push_back(cmd_b);
    pw_b = write_b;
  end

  task automatic expect_cmd(input bit sel_b, input string tag, input logic [8:0] exp);
    int unsigned n = 0;
    while ((sel_b ? qb.size() : qa.size()) == 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if ((sel_b ? qb.size() : qa.size()) == 0)
      check({tag, "_timeout"}, 32'hDEAD_BEEF, {23'b0, exp});
    else if (sel_b)
      check(tag, {23'b0, qb.pop_front()}, {23'b0, exp});
    else
      check(tag, {23'b0, qa.pop_front()}, {23'b0, exp});
  endtask

  task automatic expect_run(input string tag, input logic [8:0] exp, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) expect_cmd(1'b0, tag, exp);
  endtask

  task automatic bus(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we,
                     input logic re, input logic [31:0] exp_rd, input string tag);
    @(negedge clock);
    address = a; data = d; writeEnable = we; readEnable = re;
    @(negedge clock);
    writeEnable = '0; readEnable = 1'b0;
    check({tag, "_ack"}, {31'b0, ack}, 32'd1);
    if (re) check({tag, "_rd"}, dataOut, exp_rd);
    @(negedge clock);
    check({tag, "_ack_low"}, {31'b0, ack}, 32'd0);
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1; rst_b = 1'b1;
    address = '0; data = '0; writeEnable = '0; readEnable = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dout", dataOut, 32'd0);
    check("rst_write", {31'b0, lcd_write}, 32'd0);
    check("rst_cmd", {23'b0, lcd_command}, 32'd0);
    qa.delete();
    reset = 1'b0; rst_b = 1'b0;

    // init sequence and first blank pass of row 0
    expect_cmd(1'b0, "init_func", 9'h028);
    expect_cmd(1'b0, "init_entry", 9'h006);
    expect_cmd(1'b0, "init_disp", 9'h00C);
    expect_cmd(1'b0, "init_clr", 9'h001);
    expect_cmd(1'b0, "row0_addr", 9'h080);
    expect_run("row0_blank", 9'h120, 16);
    expect_cmd(1'b0, "row1_addr", 9'h0C0);

    bus(4'd0, 32'h0, 4'h0, 1'b1, 32'h20202020, "rd0_reset");
    bus(4'd0, 32'h48454C4C, 4'hF, 1'b0, 32'h0, "wr0");
    expect_run("row1_blank", 9'h120, 16);
    expect_cmd(1'b0, "row0_addr2", 9'h080);
    expect_cmd(1'b0, "chr_H", 9'h148);
    expect_cmd(1'b0, "chr_E", 9'h145);
    expect_cmd(1'b0, "chr_L1", 9'h14C);
    expect_cmd(1'b0, "chr_L2", 9'h14C);
    expect_run("row0_tail", 9'h120, 12);
    expect_cmd(1'b0, "row1_addr2", 9'h0C0);

    // single-byte write; concurrent read sees pre-write contents
    bus(4'd1, 32'h00410000, 4'b0100, 1'b1, 32'h20202020, "wr_rd1");
    bus(4'd1, 32'h0, 4'h0, 1'b1, 32'h20412020, "rd1");
    bus(4'd8, 32'h0, 4'h0, 1'b1, 32'h00000004, "rd_ctrl");
    expect_run("row1_blank2", 9'h120, 16);
    expect_cmd(1'b0, "row0_addr3", 9'h080);
    expect_cmd(1'b0, "chr_H3", 9'h148);
    expect_cmd(1'b0, "chr_E3", 9'h145);

    // control write mid-row 0
    bus(4'd8, 32'h00000007, 4'h1, 1'b0, 32'h0, "wr_ctrl");
    expect_cmd(1'b0, "chr_L3", 9'h14C);
    expect_cmd(1'b0, "chr_L4", 9'h14C);
    expect_cmd(1'b0, "col4", 9'h120);
    expect_cmd(1'b0, "col5", 9'h141);
    expect_run("row0_tail3", 9'h120, 10);
    expect_cmd(1'b0, "ctrl_cmd", 9'h00F);
    expect_cmd(1'b0, "row1_after_ctrl", 9'h0C0);
    expect_run("row1_blank3", 9'h120, 16);
    expect_cmd(1'b0, "row0_no_ctrl", 9'h080);

    // out-of-range accesses
    bus(4'd9, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, "wr_oor");
    bus(4'd9, 32'h0, 4'h0, 1'b1, 32'h0, "rd_oor");
    bus(4'd0, 32'h0, 4'h0, 1'b1, 32'h48454C4C, "rd0_keep");
    bus(4'd1, 32'h0, 4'h0, 1'b1, 32'h20412020, "rd1_keep");
    bus(4'd8, 32'h0, 4'h0, 1'b1, 32'h00000007, "rd_ctrl7");

    // reset while a command is in flight
    n = 0;
    while (!lcd_write && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("write_high", {31'b0, lcd_write}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_write", {31'b0, lcd_write}, 32'd0);
    check("rst_mid_cmd", {23'b0, lcd_command}, 32'd0);
    qa.delete();
    reset = 1'b0;
    expect_cmd(1'b0, "re_func", 9'h028);
    expect_cmd(1'b0, "re_entry", 9'h006);
    expect_cmd(1'b0, "re_disp", 9'h00C);
    expect_cmd(1'b0, "re_clr", 9'h001);
    expect_cmd(1'b0, "re_row0", 9'h080);
    bus(4'd0, 32'h0, 4'h0, 1'b1, 32'h20202020, "rd0_cleared");
    expect_run("re_blank", 9'h120, 4);

    // 4x20 row addressing
    expect_cmd(1'b1, "b_row0", 9'h080);
    expect_cmd(1'b1, "b_row1", 9'h0C0);
    expect_cmd(1'b1, "b_row2", 9'h094);
    expect_cmd(1'b1, "b_row3", 9'h0D4);
    expect_cmd(1'b1, "b_wrap", 9'h080);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
